// File: rtl/video_black_clamp.sv
// Black-level clamp and gain stage for the composite sample stream.
// Measures back-porch level per line and restores a fixed black code.
module video_black_clamp #(
    parameter int DATA_W       = 12,
    parameter int BP_START     = 24,
    parameter int BP_LOG2      = 5,
    parameter int LINE_TIMEOUT = 2600
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              h_sync_pulse,
    input  logic [7:0]        gain,
    input  logic [DATA_W-1:0] black_target,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] black_level,
    output logic              level_update,
    output logic              clamp_lost
);

    localparam int SUM_W  = DATA_W + BP_LOG2;
    localparam int SKIP_W = $clog2(BP_START + 1);
    localparam int LINE_W = $clog2(LINE_TIMEOUT + 1);
    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + 10;
    localparam int FRAC   = 6;

    localparam logic [SKIP_W-1:0]  SKIP_LAST = SKIP_W'(BP_START - 1);
    localparam logic [BP_LOG2-1:0] ACC_LAST  = '1;
    localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(LINE_TIMEOUT);
    localparam logic signed [PROD_W-1:0] SAT_HI =
        PROD_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACCUM,
        UPDATE
    } meas_state_t;

    meas_state_t        state, state_nx;
    logic [SKIP_W-1:0]  skip_cnt, skip_nx;
    logic [BP_LOG2-1:0] acc_cnt, acc_nx;
    logic [SUM_W-1:0]   sum, sum_nx;
    logic [DATA_W-1:0]  level_nx;
    logic [LINE_W-1:0]  line_cnt, line_nx;
    logic               lost_nx;

    logic                     s1_valid;
    logic signed [DIFF_W-1:0] s1_diff;
    logic [7:0]               s1_gain;
    logic [DATA_W-1:0]        s1_tgt;
    logic                     s2_valid;
    logic signed [PROD_W-1:0] s2_prod;
    logic [DATA_W-1:0]        s2_tgt;
    logic                     s3_valid;

    logic signed [PROD_W-1:0] mul_a, mul_b, prod_nx;
    logic signed [PROD_W-1:0] shifted, res;
    logic [DATA_W-1:0]        sat_nx;

    // Measurement state register, counters, sum and published level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            acc_cnt     <= '0;
            sum         <= '0;
            black_level <= '0;
        end else begin
            state       <= state_nx;
            skip_cnt    <= skip_nx;
            acc_cnt     <= acc_nx;
            sum         <= sum_nx;
            black_level <= level_nx;
        end
    end

    // Next-state logic; a line pulse always wins over a same-clk sample.
    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        acc_nx   = acc_cnt;
        sum_nx   = sum;
        level_nx = black_level;
        unique case (state)
            IDLE: begin
                if (h_sync_pulse) begin
                    state_nx = SKIP;
                    skip_nx  = '0;
                end
            end
            SKIP: begin
                if (h_sync_pulse) begin
                    skip_nx = '0;
                end else if (sample_valid) begin
                    if (skip_cnt == SKIP_LAST) begin
                        state_nx = ACCUM;
                        sum_nx   = '0;
                        acc_nx   = '0;
                    end else begin
                        skip_nx = skip_cnt + SKIP_W'(1);
                    end
                end
            end
            ACCUM: begin
                if (h_sync_pulse) begin
                    state_nx = SKIP;
                    skip_nx  = '0;
                    sum_nx   = '0;
                    acc_nx   = '0;
                end else if (sample_valid) begin
                    sum_nx = sum + SUM_W'(adc_data);
                    if (acc_cnt == ACC_LAST) begin
                        state_nx = UPDATE;
                    end else begin
                        acc_nx = acc_cnt + BP_LOG2'(1);
                    end
                end
            end
            UPDATE: begin
                level_nx = sum[SUM_W-1:BP_LOG2];
                skip_nx  = '0;
                state_nx = h_sync_pulse ? SKIP : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign level_update = (state == UPDATE);

    // Line-length watchdog: saturating count and lost flag.
    always_comb begin
        line_nx = line_cnt;
        lost_nx = clamp_lost;
        if (h_sync_pulse) begin
            line_nx = '0;
        end else if (sample_valid && line_cnt != LINE_MAX) begin
            line_nx = line_cnt + LINE_W'(1);
        end
        if (state_nx == UPDATE) begin
            lost_nx = 1'b0;
        end else if (line_nx == LINE_MAX) begin
            lost_nx = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt   <= '0;
            clamp_lost <= 1'b0;
        end else begin
            line_cnt   <= line_nx;
            clamp_lost <= lost_nx;
        end
    end

    // S2 multiply and S3 shift, offset and saturation.
    always_comb begin
        mul_a   = PROD_W'(s1_diff);
        mul_b   = PROD_W'($signed({1'b0, s1_gain}));
        prod_nx = mul_a * mul_b;
        shifted = s2_prod >>> FRAC;
        res     = shifted + PROD_W'($signed({1'b0, s2_tgt}));
        sat_nx  = res[DATA_W-1:0];
        if (res < 0) begin
            sat_nx = '0;
        end else if (res > SAT_HI) begin
            sat_nx = '1;
        end
    end

    // S1: offset removal, capture per-sample controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_gain  <= '0;
            s1_tgt   <= '0;
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                s1_diff <= $signed({1'b0, adc_data})
                         - $signed({1'b0, black_level});
                s1_gain <= gain;
                s1_tgt  <= black_target;
            end
        end
    end

    // S2: gain product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_tgt   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= prod_nx;
                s2_tgt  <= s1_tgt;
            end
        end
    end

    // S3: saturated output, held between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            out_data <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= sat_nx;
            end
        end
    end

    assign out_valid = s3_valid;

endmodule

// File: tb/tb_video_black_clamp.sv
// Directed bench for video_black_clamp.
// Hand-computed expectations for clamp, gain and watchdog.
module tb_video_black_clamp;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] adc_data;
    logic        h_sync_pulse;
    logic [7:0]  gain;
    logic [11:0] black_target;
    logic        out_valid;
    logic [11:0] out_data;
    logic [11:0] black_level;
    logic        level_update;
    logic        clamp_lost;

    int n_chk = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    logic lost_at_upd = 1'b0;
    int u0;

    video_black_clamp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .adc_data     (adc_data),
        .h_sync_pulse (h_sync_pulse),
        .gain         (gain),
        .black_target (black_target),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .black_level  (black_level),
        .level_update (level_update),
        .clamp_lost   (clamp_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (level_update) begin
            upd_cnt     <= upd_cnt + 1;
            lost_at_upd <= clamp_lost;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input int v);
        sample_valid = 1'b1;
        adc_data     = 12'(v);
        cyc();
        sample_valid = 1'b0;
        cyc();
    endtask

    task automatic pulse(input logic with_sample, input int v);
        h_sync_pulse = 1'b1;
        sample_valid = with_sample;
        adc_data     = 12'(v);
        cyc();
        h_sync_pulse = 1'b0;
        sample_valid = 1'b0;
        cyc();
    endtask

    task automatic bp_line(input int skip_v, input int bp_v);
        pulse(1'b0, 0);
        for (int i = 0; i < 24; i++) send(skip_v);
        for (int i = 0; i < 32; i++) send(bp_v);
        idle(2);
    endtask

    task automatic out_of(input int v, input string tag, input int exp);
        send(v);
        idle(2);
        check(tag, int'(out_data), exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        adc_data     = '0;
        h_sync_pulse = 1'b0;
        gain         = 8'd64;
        black_target = 12'd256;
        idle(3);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_black_level", int'(black_level), 0);
        check("rst_level_update", int'(level_update), 0);
        check("rst_clamp_lost", int'(clamp_lost), 0);
        rst_n = 1'b1;
        idle(4);
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_level", int'(black_level), 0);

        u0 = upd_cnt;
        bp_line(500, 1000);
        check("line1_updates", upd_cnt - u0, 1);
        check("line1_level", int'(black_level), 1000);

        sample_valid = 1'b1;
        adc_data     = 12'd2000;
        cyc();
        sample_valid = 1'b0;
        cyc();
        check("lat_not_yet", int'(out_valid), 0);
        cyc();
        check("lat_valid", int'(out_valid), 1);
        check("lat_data", int'(out_data), 1256);
        idle(3);
        check("hold_valid", int'(out_valid), 0);
        check("hold_data", int'(out_data), 1256);

        out_of(900, "below_black", 156);
        gain = 8'd96;
        out_of(2000, "gain_1p5", 1756);
        out_of(899, "neg_arith_shift", 104);
        gain = 8'd64;

        u0 = upd_cnt;
        pulse(1'b1, 4000);
        for (int i = 0; i < 24; i++) send(800);
        for (int i = 0; i < 31; i++) send(1000 + (i % 2));
        check("pulse_wins_no_upd", upd_cnt - u0, 0);
        send(1001);
        idle(1);
        check("alt_updates", upd_cnt - u0, 1);
        check("alt_truncate", int'(black_level), 1000);

        bp_line(0, 0);
        check("zero_level", int'(black_level), 0);
        gain = 8'd255;
        out_of(4095, "sat_high", 4095);
        gain = 8'd64;
        bp_line(0, 3000);
        check("level_3000", int'(black_level), 3000);
        black_target = 12'd0;
        out_of(100, "sat_low", 0);
        black_target = 12'd256;

        u0 = upd_cnt;
        pulse(1'b0, 0);
        for (int i = 0; i < 24; i++) send(50);
        for (int i = 0; i < 10; i++) send(3000);
        pulse(1'b0, 0);
        check("restart_no_upd", upd_cnt - u0, 0);
        check("restart_level_kept", int'(black_level), 3000);
        for (int i = 0; i < 24; i++) send(50);
        for (int i = 0; i < 31; i++) send(500);
        check("restart_wait", upd_cnt - u0, 0);
        send(500);
        idle(1);
        check("restart_updates", upd_cnt - u0, 1);
        check("restart_level", int'(black_level), 500);

        pulse(1'b0, 0);
        for (int i = 0; i < 24; i++) send(50);
        for (int i = 0; i < 10; i++) send(2222);
        rst_n = 1'b0;
        #2;
        check("midrst_level", int'(black_level), 0);
        check("midrst_update", int'(level_update), 0);
        check("midrst_valid", int'(out_valid), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        u0 = upd_cnt;
        for (int i = 0; i < 60; i++) send(2222);
        check("midrst_no_upd", upd_cnt - u0, 0);
        check("midrst_level_hold", int'(black_level), 0);
        bp_line(100, 1500);
        check("post_rst_upd", upd_cnt - u0, 1);
        check("post_rst_level", int'(black_level), 1500);

        pulse(1'b0, 0);
        for (int i = 0; i < 2599; i++) send(1200);
        check("lost_before", int'(clamp_lost), 0);
        check("lost_level_a", int'(black_level), 1200);
        send(1200);
        check("lost_at_limit", int'(clamp_lost), 1);
        for (int i = 0; i < 10; i++) send(3333);
        check("lost_sticky", int'(clamp_lost), 1);
        check("lost_level_hold", int'(black_level), 1200);
        u0 = upd_cnt;
        pulse(1'b0, 0);
        for (int i = 0; i < 24; i++) send(1600);
        for (int i = 0; i < 31; i++) send(1600);
        check("lost_until_upd", int'(clamp_lost), 1);
        send(1600);
        idle(1);
        check("relock_upd", upd_cnt - u0, 1);
        check("relock_lost_at_upd", int'(lost_at_upd), 0);
        check("relock_lost", int'(clamp_lost), 0);
        check("relock_level", int'(black_level), 1600);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_black_clamp.md
Name: video_black_clamp

Overview:
- Black-level restoration (DC clamp) and gain stage for the composite sample stream.
- Sits downstream of the sync separator's line pulse and upstream of the ping-pong line buffer's pixel input.
- Measures the back-porch level of every line, subtracts it from each ADC sample, applies a gain, adds a programmable black target, and saturates to 12 bits.
- The buffered image therefore has a stable black independent of input DC offset.

Parameters:
- DATA_W, 12, width of ADC samples and output data.
- BP_START, 24, valid samples after h_sync_pulse before back-porch measurement starts.
- BP_LOG2, 5, log2 of the measurement window length (window = 32 samples).
- LINE_TIMEOUT, 2600, valid samples without h_sync_pulse before clamp_lost asserts.

Ports:
- clk, input, 1, pixel clock (74.25 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- sample_valid, input, 1, one-cycle strobe marking a new ADC sample (every other clk).
- adc_data, input, DATA_W, captured ADC sample, unsigned.
- h_sync_pulse, input, 1, one-cycle pulse at line end from the sync separator.
- gain, input, 8, unsigned Q2.6 gain; 64 = 1.0. Sampled per sample.
- black_target, input, DATA_W, output code representing black.
- out_valid, output, 1, strobe marking out_data valid.
- out_data, output, DATA_W, clamped, scaled, saturated sample.
- black_level, output, DATA_W, current measured back-porch level.
- level_update, output, 1, one-cycle pulse when black_level changes.
- clamp_lost, output, 1, high while no line sync has been seen within LINE_TIMEOUT.

Behaviour:
- **Reset (async, rst_n low):**
  - All outputs 0; FSM enters IDLE.
  - Accumulator, counters and pipeline valid tags are cleared.
  - Reset mid-measurement discards the partial sum; black_level returns to 0.
- **Measurement FSM:** IDLE -> SKIP -> ACCUM -> UPDATE -> IDLE.
  - IDLE: on h_sync_pulse go to SKIP with skip_cnt=0.
  - SKIP: each sample_valid increments skip_cnt; after BP_START valid samples go to ACCUM with sum=0 and acc_cnt=0.
  - ACCUM: each sample_valid adds adc_data to sum (DATA_W+BP_LOG2 bits, no overflow possible); after 2^BP_LOG2 samples go to UPDATE.
  - UPDATE (one clk): black_level <= sum >> BP_LOG2 (truncating); level_update=1 for this clk; return to IDLE.
  - h_sync_pulse in SKIP or ACCUM restarts SKIP (skip_cnt=0, partial sum discarded); black_level is unchanged.
  - h_sync_pulse and sample_valid in the same clk: the pulse wins; that sample is not counted.
  - h_sync_pulse during UPDATE: the update completes; the FSM then goes to SKIP instead of IDLE.
- **Timeout:**
  - line_cnt counts valid samples since the last h_sync_pulse and saturates at LINE_TIMEOUT.
  - clamp_lost=1 when line_cnt==LINE_TIMEOUT.
  - clamp_lost clears on the next level_update.
  - black_level holds its last value while lost.
- **Datapath pipeline:** 3 stages, advancing every clk, valid tag shifted alongside the data.
  - S1: diff = {0,adc_data} - {0,black_level}, signed DATA_W+1.
  - S2: prod = diff * {0,gain}, signed DATA_W+10.
  - S3: res = (prod >>> 6) + black_target, arithmetic shift. res < 0 -> 0; res > 2^DATA_W-1 -> 2^DATA_W-1.
- **Timing and coherence:**
  - out_valid asserts exactly 3 clk after the sample_valid that carried the sample; out_data holds between strobes.
  - A new black_level applies to samples entering S1 from the clk after UPDATE.
  - gain and black_target are used as registered at the stage that consumes them; no mid-sample mixing within one stage.
  - Samples flow through the datapath regardless of FSM state. Back-porch and sync-tip samples are also output; gating is downstream's job.

Test Plan:
1. Reset, then idle inputs -> all outputs 0. Assert rst_n low mid-ACCUM -> black_level=0, no level_update after release until a full new window.
2. Line with back porch constant 1000, gain=64, black_target=256 -> level_update once, black_level=1000. Later input 2000 -> out_data 1256, 3 clk after its sample_valid.
3. Back porch alternating 1000/1001 over 32 samples -> black_level=1000 (truncation).
4. black_level=0, gain=255, input 4095 -> out_data 4095 (saturated high). black_level=3000, target=0, input 100 -> out_data 0 (saturated low).
5. h_sync_pulse after 10 ACCUM samples -> no update at that point. Update occurs BP_START+32 valid samples after the second pulse, using only post-pulse samples.
6. No h_sync_pulse for 2600 valid samples -> clamp_lost=1, black_level held. Next complete measurement -> clamp_lost=0 on the level_update clk.
